// File: rtl/fork_n_pkg.sv
// fork_n_pkg: shared audio-path types, default sizes and a width helper
// for the one-to-two stream fork.
package fork_n_pkg;
    localparam int DATA_WIDTH = 8;
    localparam int AUDIO_SAMPLES = 10;
    typedef enum logic [1:0] {S_IDLE, S_LATCH, S_WRITE} fork_state_t;
    // Counter width for n states, never narrower than one bit.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction
endpackage

// File: rtl/fork_n_if.sv
// fork_n_if: input FIFO read port, two output FIFO write ports and the frame pulse.
// master is the fork side, slave is the FIFO/consumer side.
interface fork_n_if #(
    parameter int DATA_WIDTH = fork_n_pkg::DATA_WIDTH
);
    logic [DATA_WIDTH-1:0] din;
    logic                  in_empty;
    logic                  in_rd_en;
    logic [DATA_WIDTH-1:0] x_dout;
    logic                  x_out_full;
    logic                  x_out_wr_en;
    logic [DATA_WIDTH-1:0] y_dout;
    logic                  y_out_full;
    logic                  y_out_wr_en;
    logic                  frame_done;
    modport master (
        input  din, in_empty, x_out_full, y_out_full,
        output in_rd_en, x_dout, x_out_wr_en, y_dout, y_out_wr_en, frame_done
    );
    modport slave (
        output din, in_empty, x_out_full, y_out_full,
        input  in_rd_en, x_dout, x_out_wr_en, y_dout, y_out_wr_en, frame_done
    );
endinterface

// File: rtl/fork_n_branch.sv
// fork_branch: one output branch of the fork; remembers that the latched sample
// still owes a write to this branch and strobes wr_en as soon as the FIFO has room.
module fork_branch (
    input  logic clock,
    input  logic reset,
    input  logic load,
    input  logic full,
    output logic wr_en,
    output logic pending
);
    import fork_n_pkg::*;
    logic pend_q, pend_d;
    always_comb pend_d = load | (pend_q & full);
    always_ff @(posedge clock or posedge reset) begin
        if (reset) pend_q <= 1'b0;
        else       pend_q <= pend_d;
    end
    assign wr_en   = pend_q & ~full;
    assign pending = pend_q;
endmodule

// File: rtl/fork_n.sv
// fork_n: pops one sample from the input FIFO and writes it once to each of the
// x and y FIFOs, with independent branch handshakes and a frame-boundary pulse.
module fork_n #(
    parameter int DATA_WIDTH    = fork_n_pkg::DATA_WIDTH,
    parameter int AUDIO_SAMPLES = fork_n_pkg::AUDIO_SAMPLES
) (
    input logic      clock,
    input logic      reset,
    fork_n_if.master bus
);
    import fork_n_pkg::*;
    localparam int            CW   = clog2(AUDIO_SAMPLES);
    localparam logic [CW-1:0] LAST = CW'(AUDIO_SAMPLES - 1);
    fork_state_t           state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  load, done, pop, pend_x, pend_y;
    fork_branch u_x (
        .clock   (clock),
        .reset   (reset),
        .load    (load),
        .full    (bus.x_out_full),
        .wr_en   (bus.x_out_wr_en),
        .pending (pend_x)
    );
    fork_branch u_y (
        .clock   (clock),
        .reset   (reset),
        .load    (load),
        .full    (bus.y_out_full),
        .wr_en   (bus.y_out_wr_en),
        .pending (pend_y)
    );
    always_comb begin
        load    = state_q == S_LATCH;
        // Done once no branch is left pending after this cycle's writes.
        done    = state_q == S_WRITE && !(pend_x && bus.x_out_full) && !(pend_y && bus.y_out_full);
        pop     = !reset && !bus.in_empty && (state_q == S_IDLE || done);
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = pop ? S_LATCH : S_IDLE;
            S_LATCH: state_d = S_WRITE;
            S_WRITE: state_d = done ? (pop ? S_LATCH : S_IDLE) : S_WRITE;
            default: state_d = S_IDLE;
        endcase
        data_d         = load ? bus.din : data_q;
        count_d        = done ? (count_q == LAST ? '0 : count_q + 1'b1) : count_q;
        bus.in_rd_en   = pop;
        bus.frame_done = done && count_q == LAST;
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            count_q <= count_d;
        end
    end
    assign bus.x_dout = data_q;
    assign bus.y_dout = data_q;
endmodule

// File: tb/tb_fork_n.sv
// tb_fork_n: scenario tasks around fork_n with a model input FIFO and
// x/y scoreboards filled on push and drained on each observed write.
module tb_fork_n;
    import fork_n_pkg::*;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;
    fork_n_if #(.DATA_WIDTH(8)) bus ();
    fork_n #(.DATA_WIDTH(8), .AUDIO_SAMPLES(10)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );
    int n_checks = 0, n_fail = 0;
    int n_rd = 0, n_xw = 0, n_yw = 0, n_fd = 0, cyc_n = 0;
    logic [7:0] in_q[$], exp_x[$], exp_y[$];
    int xt[$], fd_at[$];

    task automatic push(input logic [7:0] v);
        in_q.push_back(v);
        exp_x.push_back(v);
        exp_y.push_back(v);
        bus.in_empty = 1'b0;
    endtask

    // One clock: observe outputs at the falling edge, then model the input FIFO pop.
    task automatic cyc();
        logic       rd;
        logic [7:0] e;
        @(negedge clock);
        cyc_n++;
        if (bus.in_rd_en) n_rd++;
        if (bus.in_rd_en) begin
            n_checks++;
            if (bus.in_empty) begin
                n_fail++;
                $display("FAIL rd_while_empty in_rd_en=%b in_empty=%b required in_rd_en=0", bus.in_rd_en, bus.in_empty);
            end
        end
        if (bus.x_out_wr_en) begin
            n_xw++;
            xt.push_back(cyc_n);
            n_checks++;
            if (exp_x.size() == 0) begin
                n_fail++;
                $display("FAIL x_extra got %0h with no write expected", bus.x_dout);
            end else begin
                e = exp_x.pop_front();
                if (bus.x_dout !== e) begin
                    n_fail++;
                    $display("FAIL x_data got %0h required %0h", bus.x_dout, e);
                end
            end
        end
        if (bus.y_out_wr_en) begin
            n_yw++;
            n_checks++;
            if (exp_y.size() == 0) begin
                n_fail++;
                $display("FAIL y_extra got %0h with no write expected", bus.y_dout);
            end else begin
                e = exp_y.pop_front();
                if (bus.y_dout !== e) begin
                    n_fail++;
                    $display("FAIL y_data got %0h required %0h", bus.y_dout, e);
                end
            end
        end
        if (bus.frame_done) begin
            n_fd++;
            fd_at.push_back(n_xw);
        end
        rd = bus.in_rd_en;
        @(posedge clock);
        #1;
        if (rd && in_q.size() > 0) bus.din = in_q.pop_front();
        bus.in_empty = in_q.size() == 0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && (exp_x.size() != 0 || exp_y.size() != 0 || in_q.size() != 0); i++) cyc();
        cyc();
        n_checks++;
        if (exp_x.size() != 0 || exp_y.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout x_left=%0d y_left=%0d required 0", exp_x.size(), exp_y.size());
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        bus.in_empty = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        n_checks += 8;
        if (bus.in_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd got %b required 0", bus.in_rd_en); end
        if (bus.x_out_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_xw got %b required 0", bus.x_out_wr_en); end
        if (bus.y_out_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_yw got %b required 0", bus.y_out_wr_en); end
        if (bus.frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_fd got %b required 0", bus.frame_done); end
        if (bus.x_dout !== 8'h00) begin n_fail++; $display("FAIL reset_xdout got %0h required 0", bus.x_dout); end
        if (bus.y_dout !== 8'h00) begin n_fail++; $display("FAIL reset_ydout got %0h required 0", bus.y_dout); end
        if (dut.state_q !== S_IDLE) begin n_fail++; $display("FAIL reset_state got %0d required %0d", dut.state_q, S_IDLE); end
        if (dut.count_q !== 4'd0) begin n_fail++; $display("FAIL reset_count got %0d required 0", dut.count_q); end
        bus.in_empty = 1'b1;
        reset = 1'b0;
        cyc();
    endtask

    task automatic test_stream();
        xt.delete();
        push(8'd5);
        push(8'hFD);
        push(8'd127);
        drain();
        n_checks += 3;
        if (xt.size() != 3) begin
            n_fail++;
            $display("FAIL stream_writes got %0d required 3", xt.size());
        end else begin
            if (xt[1] - xt[0] != 2) begin n_fail++; $display("FAIL stream_gap1 got %0d required 2", xt[1] - xt[0]); end
            if (xt[2] - xt[1] != 2) begin n_fail++; $display("FAIL stream_gap2 got %0d required 2", xt[2] - xt[1]); end
        end
    endtask

    task automatic test_one_full();
        int rb, xb, yb;
        rb = n_rd; xb = n_xw; yb = n_yw;
        bus.x_out_full = 1'b1;
        push(8'd42);
        push(8'd43);
        repeat (8) cyc();
        n_checks += 5;
        if (n_rd - rb != 1) begin n_fail++; $display("FAIL xfull_pops got %0d required 1", n_rd - rb); end
        if (n_yw - yb != 1) begin n_fail++; $display("FAIL xfull_ywrites got %0d required 1", n_yw - yb); end
        if (n_xw - xb != 0) begin n_fail++; $display("FAIL xfull_xwrites got %0d required 0", n_xw - xb); end
        bus.x_out_full = 1'b0;
        #1;
        if (bus.x_out_wr_en !== 1'b1) begin n_fail++; $display("FAIL xfull_release_xw got %b required 1", bus.x_out_wr_en); end
        if (bus.in_rd_en !== 1'b1) begin n_fail++; $display("FAIL xfull_release_rd got %b required 1", bus.in_rd_en); end
        drain();
    endtask

    task automatic test_both_full();
        int rb, xb, yb;
        rb = n_rd; xb = n_xw; yb = n_yw;
        bus.x_out_full = 1'b1;
        bus.y_out_full = 1'b1;
        push(8'h80);
        push(8'h11);
        repeat (6) cyc();
        n_checks += 6;
        if (n_rd - rb != 1) begin n_fail++; $display("FAIL bothfull_pops got %0d required 1", n_rd - rb); end
        if (n_xw - xb != 0) begin n_fail++; $display("FAIL bothfull_xwrites got %0d required 0", n_xw - xb); end
        if (n_yw - yb != 0) begin n_fail++; $display("FAIL bothfull_ywrites got %0d required 0", n_yw - yb); end
        bus.x_out_full = 1'b0;
        bus.y_out_full = 1'b0;
        #1;
        if (bus.x_out_wr_en !== 1'b1) begin n_fail++; $display("FAIL bothdrop_xw got %b required 1", bus.x_out_wr_en); end
        if (bus.y_out_wr_en !== 1'b1) begin n_fail++; $display("FAIL bothdrop_yw got %b required 1", bus.y_out_wr_en); end
        if (bus.in_rd_en !== 1'b1) begin n_fail++; $display("FAIL bothdrop_rd got %b required 1", bus.in_rd_en); end
        drain();
    endtask

    task automatic test_frame();
        int xb, fb;
        apply_reset();
        fd_at.delete();
        xb = n_xw; fb = n_fd;
        for (int i = 0; i < 25; i++) push(8'(i * 7 - 40));
        drain();
        n_checks += 2;
        if (n_fd - fb != 2) begin
            n_fail++;
            $display("FAIL frame_pulses got %0d required 2", n_fd - fb);
        end else if (fd_at[0] - xb != 10 || fd_at[1] - xb != 20) begin
            n_fail++;
            $display("FAIL frame_positions got %0d,%0d required 10,20", fd_at[0] - xb, fd_at[1] - xb);
        end
        if (dut.count_q !== 4'd5) begin n_fail++; $display("FAIL frame_count got %0d required 5", dut.count_q); end
    endtask

    task automatic test_reset_mid();
        int xb, yb;
        apply_reset();
        for (int i = 0; i < 7; i++) push(8'(100 + i));
        drain();
        n_checks++;
        if (dut.count_q !== 4'd7) begin n_fail++; $display("FAIL mid_count_before got %0d required 7", dut.count_q); end
        bus.x_out_full = 1'b1;
        yb = n_yw;
        push(8'h33);
        push(8'h44);
        for (int i = 0; i < 20 && n_yw == yb; i++) cyc();
        n_checks++;
        if (n_yw == yb) begin n_fail++; $display("FAIL mid_ywrite_timeout got 0 writes required 1"); end
        reset = 1'b1;
        #1;
        n_checks += 6;
        if (bus.in_rd_en !== 1'b0) begin n_fail++; $display("FAIL mid_rd got %b required 0", bus.in_rd_en); end
        if (bus.x_out_wr_en !== 1'b0) begin n_fail++; $display("FAIL mid_xw got %b required 0", bus.x_out_wr_en); end
        if (bus.y_out_wr_en !== 1'b0) begin n_fail++; $display("FAIL mid_yw got %b required 0", bus.y_out_wr_en); end
        if (bus.frame_done !== 1'b0) begin n_fail++; $display("FAIL mid_fd got %b required 0", bus.frame_done); end
        if (dut.count_q !== 4'd0) begin n_fail++; $display("FAIL mid_count got %0d required 0", dut.count_q); end
        if (bus.x_dout !== 8'h00) begin n_fail++; $display("FAIL mid_xdout got %0h required 0", bus.x_dout); end
        // The x write still owed for 0x33 is discarded by the reset.
        void'(exp_x.pop_front());
        bus.x_out_full = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        xb = n_xw; yb = n_yw;
        drain();
        n_checks += 2;
        if (n_xw - xb != 1) begin n_fail++; $display("FAIL mid_after_xwrites got %0d required 1", n_xw - xb); end
        if (n_yw - yb != 1) begin n_fail++; $display("FAIL mid_after_ywrites got %0d required 1", n_yw - yb); end
    endtask

    task automatic test_empty();
        int rb, xb, yb, fb;
        rb = n_rd; xb = n_xw; yb = n_yw; fb = n_fd;
        repeat (50) cyc();
        n_checks += 4;
        if (n_rd != rb) begin n_fail++; $display("FAIL empty_pops got %0d required 0", n_rd - rb); end
        if (n_xw != xb) begin n_fail++; $display("FAIL empty_xwrites got %0d required 0", n_xw - xb); end
        if (n_yw != yb) begin n_fail++; $display("FAIL empty_ywrites got %0d required 0", n_yw - yb); end
        if (n_fd != fb) begin n_fail++; $display("FAIL empty_frames got %0d required 0", n_fd - fb); end
    endtask

    initial begin
        bus.din = 8'h00;
        bus.in_empty = 1'b1;
        bus.x_out_full = 1'b0;
        bus.y_out_full = 1'b0;
        test_reset();
        test_stream();
        test_one_full();
        test_both_full();
        test_frame();
        test_reset_mid();
        test_empty();
        n_checks++;
        if (exp_x.size() != 0 || exp_y.size() != 0) begin
            n_fail++;
            $display("FAIL leftover x=%0d y=%0d required 0", exp_x.size(), exp_y.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
